shift_rx_ctrl: RTL and testbench
================================

# shift_rx_ctrl

Serial-to-parallel receive controller that sequences a DATA_W-bit shift register. It detects a start bit, shifts in exactly DATA_W data bits on bit-enable strobes, and checks the stop bit. It then presents the assembled word on a valid/ready output port, flagging framing errors and overruns. It sits between a serial pin (already synchronised, with a baud/bit strobe supplied externally) and a parallel consumer.

## Interface
- DATA_W, default 4, number of data bits per frame (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  one-cycle bit strobe; sin is sampled only when high
- sin  input  1  serial line; idle high
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- out_data  output  DATA_W  received word; reset 0
- out_valid  output  1  word available; reset 0
- frame_err  output  1  one-cycle pulse on bad stop bit; reset 0
- overrun  output  1  one-cycle pulse when an unconsumed word is overwritten; reset 0
- busy  output  1  high whenever state != IDLE; reset 0

## Operation
- Frame format: start bit 0, then DATA_W data bits MSB first, then stop bit 1.
- Shift direction: each sampled bit enters bit 0 and existing bits move up one position, so the first data bit ends in bit DATA_W-1.
- Bit counter: width $clog2(DATA_W), cleared on start detect.
- States:
  - IDLE: on bit_en && !sin, go to DATA and clear the counter. bit_en && sin stays in IDLE.
  - DATA: on bit_en, shift in sin and increment the counter. When the counter == DATA_W-1 on a strobe, go to STOP after that shift.
  - STOP, on bit_en && sin: copy the shift register to out_data, set out_valid, go to IDLE.
  - STOP, on bit_en && !sin: pulse frame_err, discard the word (out_data/out_valid untouched), go to RECOVER.
  - RECOVER: wait for bit_en && sin, then go to IDLE. This prevents a stuck-low line from being read as repeated starts.
- Cycles without bit_en never change state, counter or shift register.
- Output handshake: out_valid clears on out_valid && out_ready unless a new load happens in the same cycle.
- Load while out_valid=1 and out_ready=0: overwrite out_data, keep out_valid=1, pulse overrun.
- Load while out_valid=1 and out_ready=1: the old word is consumed, the new word is loaded, out_valid stays 1, no overrun.
- Reset (any cycle, including mid-frame): state IDLE, counter 0, shift register 0, all outputs 0. No partial word is ever presented.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs except none; busy is decoded from the state register.
- Latency: out_valid and out_data update on the clock edge that samples the stop-bit strobe; they are visible the following cycle.
- A frame consumes DATA_W+2 bit_en strobes from start bit to stop bit.
- frame_err and overrun are high for exactly one clk cycle, coincident with the cycle out_valid/out_data would update.
- bit_en may be asserted on consecutive cycles (one bit per clock). The block must sustain back-to-back frames with no idle bit between stop and the next start.

## Structure
- Shared package shift_rx_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2, ST_RECOVER=2'd3
  - default DATA_W constant
- Sub-module shift_reg_en:
  - DATA_W-wide shift register with synchronous active-high reset and shift enable (shifts toward MSB)
  - instantiated once, enable = bit_en && state==ST_DATA
- The FSM, counter, output holding register and flag logic live in shift_rx_ctrl.

## Test plan
- Reset then frame 0,1,0,1,1,1 (start, 1011, stop) with bit_en every cycle → out_data=4'b1011, out_valid=1 one cycle after the stop strobe; frame_err=0.
- Same frame with bit_en every 3rd cycle, sin toggling between strobes → identical result; non-strobe values are ignored.
- Frame start, 0110, stop=0 → frame_err pulses once and out_valid stays 0. Holding sin=0 for 5 strobes produces no new frame; sin=1 then a valid frame 1001 → out_data=4'b1001.
- Two back-to-back frames 1100 then 0011 with out_ready=0 → first out_data=4'b1100; second load gives out_data=4'b0011, overrun pulses once, out_valid stays 1. Repeating with out_ready=1 on the second load cycle → no overrun.
- rst asserted after 2 data bits of a frame → next cycle all outputs 0 and busy=0. A following clean frame 0101 is received correctly.

Source files
------------

// File: rtl/shift_rx_pkg.sv
// Shared constants for the serial receive controller: state encoding and default frame width.
package shift_rx_pkg;

  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_STOP    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/shift_reg_en.sv
// Enabled shift register; new bits enter at bit 0 and move toward the MSB.
module shift_reg_en #(
  parameter int DATA_W = shift_rx_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= {q[DATA_W-2:0], din};
  end

endmodule

// File: rtl/shift_rx_ctrl.sv
// Receive sequencer: start detect, DATA_W data bits MSB first, stop check, and a
// single-entry valid/ready output holding register with framing-error and overrun pulses.
module shift_rx_ctrl
  import shift_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  state_t            state, nstate;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              load, bad_stop;

  shift_reg_en #(.DATA_W(DATA_W)) u_shreg (
    .clk (clk),
    .rst (rst),
    .en  (bit_en && (state == ST_DATA)),
    .din (sin),
    .q   (shreg)
  );

  always_comb begin
    nstate   = state;
    load     = 1'b0;
    bad_stop = 1'b0;
    case (state)
      ST_IDLE:    if (bit_en && !sin) nstate = ST_DATA;
      ST_DATA:    if (bit_en && (cnt == CNT_LAST)) nstate = ST_STOP;
      ST_STOP: begin
        if (bit_en) begin
          load     = sin;
          bad_stop = !sin;
          nstate   = sin ? ST_IDLE : ST_RECOVER;
        end
      end
      // Hold here until the line returns high so a stuck-low line is not a stream of starts.
      ST_RECOVER: if (bit_en && sin) nstate = ST_IDLE;
      default:    nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && bit_en && !sin) cnt <= '0;
      else if (state == ST_DATA && bit_en)    cnt <= cnt + 1'b1;
    end
  end

  // A load in the same cycle as a consume wins; overrun only when the old word was never taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= load && out_valid && !out_ready;
      if (load) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Directed bench for shift_rx_ctrl: a table of back-to-back frames plus hand-written corner sequences.
module tb_shift_rx_ctrl;

  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst, bit_en, sin, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, frame_err, overrun, busy;

  int errors = 0;
  int checks = 0;

  shift_rx_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .sin       (sin),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] word;
    logic       stop;
    logic       rdy;     // out_ready on the stop-strobe cycle only
    logic [3:0] e_data;
    logic       e_valid;
    logic       e_ferr;
    logic       e_ovr;
    logic       e_busy;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One strobe with sin=b, then gap strobe-free cycles with sin toggling as noise.
  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b1;
    sin    = b;
    cyc();
    bit_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      sin = ~sin;
      cyc();
    end
  endtask

  task automatic send_frame(input logic [3:0] w, input logic stop, input int gap);
    send_bit(1'b0, gap);
    for (int i = 3; i >= 0; i--) send_bit(w[i], gap);
    send_bit(stop, 0);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] d, input logic v,
                         input logic fe, input logic ov, input logic bz);
    chk({nm, ".data"},  32'(out_data),  32'(d));
    chk({nm, ".valid"}, 32'(out_valid), 32'(v));
    chk({nm, ".ferr"},  32'(frame_err), 32'(fe));
    chk({nm, ".ovr"},   32'(overrun),   32'(ov));
    chk({nm, ".busy"},  32'(busy),      32'(bz));
  endtask

  initial begin
    int fe_cnt;
    vecs[0] = '{4'b1011, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b1100, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b0011, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'b0110, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{4'b1001, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'b0101, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{4'b1110, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; bit_en = 1'b0; sin = 1'b1; out_ready = 1'b0;
    cyc(); cyc();
    chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Slow strobes with noise between them; word must appear only after the stop strobe.
    send_bit(1'b0, 2);
    send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
    chk("slow.prestop_valid", 32'(out_valid), 32'd0);
    chk("slow.prestop_busy",  32'(busy),      32'd1);
    send_bit(1'b1, 0);
    chk_all("slow", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("consume.valid", 32'(out_valid), 32'd0);

    // Back-to-back frames, bit_en every cycle.
    for (int k = 0; k < 7; k++) begin
      send_bit(1'b0, 0);
      for (int i = 3; i >= 0; i--) send_bit(vecs[k].word[i], 0);
      out_ready = vecs[k].rdy;
      send_bit(vecs[k].stop, 0);
      out_ready = 1'b0;
      chk_all($sformatf("vec%0d", k), vecs[k].e_data, vecs[k].e_valid,
              vecs[k].e_ferr, vecs[k].e_ovr, vecs[k].e_busy);
      if (!vecs[k].stop) send_bit(1'b1, 0);
    end
    chk("vec6.ovr_clears", 32'(overrun), 32'd0);

    // Bad stop, then stuck-low line must not start new frames.
    rst = 1'b1; cyc(); rst = 1'b0;
    send_frame(4'b0110, 1'b0, 0);
    chk_all("badstop", 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    fe_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 0);
      if (frame_err) fe_cnt++;
    end
    chk("stuck.ferr_pulses", 32'(fe_cnt), 32'd0);
    chk_all("stuck", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 0);
    chk("recover.busy", 32'(busy), 32'd0);
    send_frame(4'b1001, 1'b1, 0);
    chk_all("after_recover", 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame after two data bits.
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    chk("midframe.busy", 32'(busy), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_all("midrst", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0101, 1'b1, 0);
    chk_all("post_rst", 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
